// File: rtl/fetch_req.sv
// rtl/fetch_req.sv - sequential instruction-word read requester with decoder credits and jump drain
module fetch_req #(
  parameter int ADDR_W  = 20,
  parameter int CREDITS = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iJumped,
  input  logic [ADDR_W-1:0] iJumpAddr,
  input  logic              iCredit,
  output logic              oMemReq,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [1:0]        oMemIndex,
  input  logic              iMemGnt,
  input  logic              iMemAck,
  output logic              oDiscard,
  output logic              oBusy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        index_q, index_d;
  logic [2:0]        credits_q, credits_d;
  logic              grant;
  logic              stale;

  assign grant = (state_q == S_REQ) && iMemGnt;

  // An old word is still owed by memory: it must be drained before the new stream starts.
  assign stale = ((state_q == S_WAIT)  && !iMemAck) ||
                 ((state_q == S_DRAIN) && !iMemAck) ||
                 grant;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    index_d   = index_q;
    credits_d = credits_q;

    if (grant && !iCredit) begin
      credits_d = credits_q - 3'd1;
    end else if (!grant && iCredit && (credits_q != CRED_MAX)) begin
      credits_d = credits_q + 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (credits_q != 3'd0) state_d = S_REQ;
      end
      S_REQ: begin
        if (grant) begin
          state_d = S_WAIT;
          addr_d  = addr_q + ADDR_W'(4);
          index_d = 2'd0;
        end
      end
      S_WAIT: begin
        if (iMemAck) state_d = (credits_d != 3'd0) ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (iMemAck) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (iJumped) begin
      addr_d    = {iJumpAddr[ADDR_W-1:2], 2'b00};
      index_d   = iJumpAddr[1:0];
      credits_d = CRED_MAX;
      state_d   = stale ? S_DRAIN : S_REQ;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      index_q   <= 2'd0;
      credits_q <= CRED_MAX;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      index_q   <= index_d;
      credits_q <= credits_d;
    end
  end

  assign oMemReq   = (state_q == S_REQ);
  assign oBusy     = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign oDiscard  = (state_q == S_DRAIN);
  assign oMemAddr  = addr_q;
  assign oMemIndex = index_q;

endmodule

// File: tb/tb_fetch_req.sv
// tb/tb_fetch_req.sv - directed scenario bench for fetch_req
module tb_fetch_req;
  logic        iClk = 1'b0;
  logic        iRst;
  logic        iJumped;
  logic [19:0] iJumpAddr;
  logic        iCredit;
  logic        oMemReq;
  logic [19:0] oMemAddr;
  logic [1:0]  oMemIndex;
  logic        iMemGnt;
  logic        iMemAck;
  logic        oDiscard;
  logic        oBusy;

  int total = 0;
  int bad   = 0;

  fetch_req #(.ADDR_W(20), .CREDITS(2)) dut (
    .iClk(iClk), .iRst(iRst), .iJumped(iJumped), .iJumpAddr(iJumpAddr),
    .iCredit(iCredit), .oMemReq(oMemReq), .oMemAddr(oMemAddr),
    .oMemIndex(oMemIndex), .iMemGnt(iMemGnt), .iMemAck(iMemAck),
    .oDiscard(oDiscard), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_ack();
    iMemAck = 1'b1;
    step();
    iMemAck = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iJumped = 1'b0; iJumpAddr = '0; iCredit = 1'b0; iMemGnt = 1'b0; iMemAck = 1'b0;
    step(); step();
    total++; if (oMemReq !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", oMemReq); end
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h want=0", oBusy); end
    total++; if (oDiscard !== 1'b0) begin bad++; $display("FAIL rst_discard got=%0h want=0", oDiscard); end
    total++; if (oMemAddr !== 20'h0) begin bad++; $display("FAIL rst_addr got=%0h want=0", oMemAddr); end
    total++; if (oMemIndex !== 2'd0) begin bad++; $display("FAIL rst_index got=%0h want=0", oMemIndex); end
    total++; if (dut.credits_q !== 3'd2) begin bad++; $display("FAIL rst_credits got=%0d want=2", dut.credits_q); end
    iRst = 1'b0;
  endtask

  task automatic test_sequential();
    iMemGnt = 1'b1;
    step();
    total++; if (oMemReq !== 1'b1 || oMemAddr !== 20'h00000) begin bad++; $display("FAIL seq_req0 got=%0h/%0h want=1/0", oMemReq, oMemAddr); end
    step();
    total++; if (oBusy !== 1'b1 || oMemReq !== 1'b0) begin bad++; $display("FAIL seq_wait0 got busy=%0h req=%0h want 1/0", oBusy, oMemReq); end
    step(); do_ack();
    total++; if (oMemReq !== 1'b1 || oMemAddr !== 20'h00004) begin bad++; $display("FAIL seq_req1 got=%0h/%0h want=1/4", oMemReq, oMemAddr); end
    step(); step(); do_ack();
    total++; if (oMemReq !== 1'b0 || oBusy !== 1'b0) begin bad++; $display("FAIL seq_idle got req=%0h busy=%0h want 0/0", oMemReq, oBusy); end
    step();
    total++; if (oMemReq !== 1'b0) begin bad++; $display("FAIL seq_idle_hold got=%0h want=0", oMemReq); end
    total++; if (oMemAddr !== 20'h00008) begin bad++; $display("FAIL seq_addr got=%0h want=8", oMemAddr); end
  endtask

  task automatic test_credit_return();
    iCredit = 1'b1;
    step();
    iCredit = 1'b0;
    step();
    total++; if (oMemReq !== 1'b1 || oMemAddr !== 20'h00008) begin bad++; $display("FAIL cred_req got=%0h/%0h want=1/8", oMemReq, oMemAddr); end
    total++; if (oMemIndex !== 2'd0) begin bad++; $display("FAIL cred_index got=%0h want=0", oMemIndex); end
    step(); step(); do_ack();
    total++; if (oMemReq !== 1'b0 || oBusy !== 1'b0) begin bad++; $display("FAIL cred_idle got req=%0h busy=%0h want 0/0", oMemReq, oBusy); end
  endtask

  task automatic test_jump_idle();
    iJumped = 1'b1; iJumpAddr = 20'h12347;
    step();
    iJumped = 1'b0;
    total++; if (oMemReq !== 1'b1 || oMemAddr !== 20'h12344) begin bad++; $display("FAIL jidle_req got=%0h/%0h want=1/12344", oMemReq, oMemAddr); end
    total++; if (oMemIndex !== 2'd3) begin bad++; $display("FAIL jidle_index got=%0h want=3", oMemIndex); end
    step(); step(); do_ack();
    total++; if (oMemReq !== 1'b1 || oMemAddr !== 20'h12348) begin bad++; $display("FAIL jidle_next got=%0h/%0h want=1/12348", oMemReq, oMemAddr); end
    total++; if (oMemIndex !== 2'd0) begin bad++; $display("FAIL jidle_next_index got=%0h want=0", oMemIndex); end
    step();
  endtask

  task automatic test_jump_drain();
    iJumped = 1'b1; iJumpAddr = 20'h00100;
    step();
    iJumped = 1'b0;
    total++; if (dut.credits_q !== 3'd2) begin bad++; $display("FAIL drain_credits_reload got=%0d want=2", dut.credits_q); end
    for (int i = 0; i < 3; i++) begin
      total++; if (oDiscard !== 1'b1 || oMemReq !== 1'b0) begin bad++; $display("FAIL drain_discard%0d got disc=%0h req=%0h want 1/0", i, oDiscard, oMemReq); end
      if (i < 2) step();
    end
    do_ack();
    total++; if (oDiscard !== 1'b0 || oMemReq !== 1'b1) begin bad++; $display("FAIL drain_end got disc=%0h req=%0h want 0/1", oDiscard, oMemReq); end
    total++; if (oMemAddr !== 20'h00100 || oMemIndex !== 2'd0) begin bad++; $display("FAIL drain_addr got=%0h/%0h want=100/0", oMemAddr, oMemIndex); end
    step();
    total++; if (dut.credits_q !== 3'd1) begin bad++; $display("FAIL drain_credits got=%0d want=1", dut.credits_q); end
  endtask

  task automatic test_jump_with_ack();
    iJumped = 1'b1; iJumpAddr = 20'h0A00E; iMemAck = 1'b1;
    step();
    iJumped = 1'b0; iMemAck = 1'b0;
    total++; if (oDiscard !== 1'b0 || oMemReq !== 1'b1) begin bad++; $display("FAIL jack_state got disc=%0h req=%0h want 0/1", oDiscard, oMemReq); end
    total++; if (oMemAddr !== 20'h0A00C || oMemIndex !== 2'd2) begin bad++; $display("FAIL jack_addr got=%0h/%0h want=a00c/2", oMemAddr, oMemIndex); end
    step();
    total++; if (oDiscard !== 1'b0 || oBusy !== 1'b1 || oMemAddr !== 20'h0A010) begin bad++; $display("FAIL jack_wait got disc=%0h busy=%0h addr=%0h want 0/1/a010", oDiscard, oBusy, oMemAddr); end
  endtask

  task automatic test_wrap_and_reset();
    iRst = 1'b1; #1; iRst = 1'b0;
    iJumped = 1'b1; iJumpAddr = 20'hFFFFC;
    step();
    iJumped = 1'b0;
    total++; if (oMemAddr !== 20'hFFFFC || oMemReq !== 1'b1) begin bad++; $display("FAIL wrap_first got=%0h/%0h want=fffc/1", oMemAddr, oMemReq); end
    step(); do_ack();
    total++; if (oMemAddr !== 20'h00000 || oMemReq !== 1'b1) begin bad++; $display("FAIL wrap_second got=%0h/%0h want=0/1", oMemAddr, oMemReq); end
    iCredit = 1'b1;
    step();
    iCredit = 1'b0;
    total++; if (dut.credits_q !== 3'd1) begin bad++; $display("FAIL gnt_credit_same got=%0d want=1", dut.credits_q); end
    total++; if (oBusy !== 1'b1 || oMemAddr !== 20'h00004) begin bad++; $display("FAIL wrap_wait got busy=%0h addr=%0h want 1/4", oBusy, oMemAddr); end
    iMemGnt = 1'b0;
    iRst = 1'b1;
    #1;
    total++; if (oBusy !== 1'b0 || oMemReq !== 1'b0 || oDiscard !== 1'b0) begin bad++; $display("FAIL async_rst got busy=%0h req=%0h disc=%0h want 0/0/0", oBusy, oMemReq, oDiscard); end
    total++; if (oMemAddr !== 20'h0) begin bad++; $display("FAIL async_rst_addr got=%0h want=0", oMemAddr); end
    step();
    iRst = 1'b0; iMemAck = 1'b1;
    step();
    total++; if (oMemReq !== 1'b1 || oBusy !== 1'b0 || oMemAddr !== 20'h0) begin bad++; $display("FAIL ack_idle got req=%0h busy=%0h addr=%0h want 1/0/0", oMemReq, oBusy, oMemAddr); end
    step();
    iMemAck = 1'b0;
    total++; if (oMemReq !== 1'b1 || oBusy !== 1'b0 || dut.credits_q !== 3'd2) begin bad++; $display("FAIL ack_req got req=%0h busy=%0h cred=%0d want 1/0/2", oMemReq, oBusy, dut.credits_q); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_credit_return();
    test_jump_idle();
    test_jump_drain();
    test_jump_with_ack();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
